// File: rtl/aq_djpeg_idct_outbuf.sv
// Ping-pong 2x64 pixel buffer between the IDCT and a ready/valid raster consumer; 1-cycle full-to-valid latency.
// Define AQ_DJPEG_OUTBUF_CLAMP_EN to saturate level-shifted samples to 0..255 instead of wrapping.
module aq_djpeg_idct_outbuf (
  input  logic       clk,
  input  logic       rst,
  input  logic       ProcessInit,
  input  logic       DataInEnable,
  input  logic [2:0] DataInPage,
  input  logic [1:0] DataInCount,
  input  logic [8:0] DataIn0,
  input  logic [8:0] DataIn1,
  output logic       DataInIdle,
  output logic       OutValid,
  input  logic       OutReady,
  output logic [7:0] OutData,
  output logic [5:0] OutIndex,
  output logic       OutLast,
  output logic       Overflow
);

  typedef enum logic {ST_IDLE, ST_STREAM} state_t;

  state_t      state_q, state_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  full_q, full_d;
  logic        overflow_q, overflow_d;
  logic [5:0]  index_q, index_d;
  logic        valid_q, valid_d;
  logic        last_q, last_d;

  logic [7:0]  bank_q [2][64];

  logic signed [9:0] sum0, sum1;
  logic [7:0]  pix0, pix1;
  logic        wr_en;
  logic        blk_end;
  logic [5:0]  wr_addr0, wr_addr1;

  assign sum0 = $signed({DataIn0[8], DataIn0}) + 10'sd128;
  assign sum1 = $signed({DataIn1[8], DataIn1}) + 10'sd128;

`ifdef AQ_DJPEG_OUTBUF_CLAMP_EN
  always_comb begin
    pix0 = sum0[7:0];
    pix1 = sum1[7:0];
    if (sum0 < 10'sd0)        pix0 = 8'd0;
    else if (sum0 > 10'sd255) pix0 = 8'd255;
    if (sum1 < 10'sd0)        pix1 = 8'd0;
    else if (sum1 > 10'sd255) pix1 = 8'd255;
  end
`else
  logic unused_sum_hi;
  assign unused_sum_hi = ^{sum0[9:8], sum1[9:8]};
  assign pix0 = sum0[7:0];
  assign pix1 = sum1[7:0];
`endif

  assign wr_addr0 = {DataInPage, DataInCount, 1'b0};
  assign wr_addr1 = {DataInPage, DataInCount, 1'b1};
  assign blk_end  = (DataInPage == 3'd7) && (DataInCount == 2'd3);
  // Writes are gated by the clears so an aborted block never lands in a bank.
  assign wr_en    = DataInEnable && !full_q[wr_ptr_q] && !rst && !ProcessInit;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      bank_q[wr_ptr_q][wr_addr0] <= pix0;
      bank_q[wr_ptr_q][wr_addr1] <= pix1;
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    full_d     = full_q;
    overflow_d = overflow_q;
    index_d    = index_q;

    if (DataInEnable) begin
      if (!full_q[wr_ptr_q]) begin
        if (blk_end) begin
          full_d[wr_ptr_q] = 1'b1;
          wr_ptr_d         = ~wr_ptr_q;
        end
      end else begin
        overflow_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (full_q[rd_ptr_q]) begin
          state_d = ST_STREAM;
          index_d = 6'd0;
        end
      end
      default: begin
        if (OutReady) begin
          if (index_q == 6'd63) begin
            full_d[rd_ptr_q] = 1'b0;
            rd_ptr_d         = ~rd_ptr_q;
            index_d          = 6'd0;
            // Includes a block completing this very cycle, keeping back-to-back streams gapless.
            state_d          = full_d[~rd_ptr_q] ? ST_STREAM : ST_IDLE;
          end else begin
            index_d = index_q + 6'd1;
          end
        end
      end
    endcase

    valid_d = (state_d == ST_STREAM);
    last_d  = valid_d && (index_d == 6'd63);
  end

  always_ff @(posedge clk) begin
    if (rst || ProcessInit) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      full_q     <= 2'b00;
      overflow_q <= 1'b0;
      index_q    <= 6'd0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
      index_q    <= index_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
    end
  end

  assign DataInIdle = !full_q[wr_ptr_q];
  assign OutValid   = valid_q;
  assign OutIndex   = index_q;
  assign OutLast    = last_q;
  assign Overflow   = overflow_q;
  assign OutData    = valid_q ? bank_q[rd_ptr_q][index_q] : 8'd0;

endmodule

// File: tb/tb_aq_djpeg_idct_outbuf.sv
// Directed bench for aq_djpeg_idct_outbuf: table-driven conversion vectors plus multi-cycle corner sequences.
module tb_aq_djpeg_idct_outbuf;

  logic       clk = 1'b0;
  logic       rst, ProcessInit, DataInEnable, OutReady;
  logic [2:0] DataInPage;
  logic [1:0] DataInCount;
  logic [8:0] DataIn0, DataIn1;
  logic       DataInIdle, OutValid, OutLast, Overflow;
  logic [7:0] OutData;
  logic [5:0] OutIndex;

  always #5 clk = ~clk;

  aq_djpeg_idct_outbuf dut (
    .clk(clk), .rst(rst), .ProcessInit(ProcessInit),
    .DataInEnable(DataInEnable), .DataInPage(DataInPage), .DataInCount(DataInCount),
    .DataIn0(DataIn0), .DataIn1(DataIn1), .DataInIdle(DataInIdle),
    .OutValid(OutValid), .OutReady(OutReady), .OutData(OutData),
    .OutIndex(OutIndex), .OutLast(OutLast), .Overflow(Overflow)
  );

  typedef struct {
    logic signed [8:0] d0;
    logic signed [8:0] d1;
    logic [7:0]        e0;
    logic [7:0]        e1;
  } vec_t;

  vec_t              vtab [8];
  logic signed [8:0] blk_d [2][64];
  logic [7:0]        blk_e [2][64];
  int                checks = 0;
  int                failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ProcessInit = 1'b0; DataInEnable = 1'b0; OutReady = 1'b0;
    DataInPage = '0; DataInCount = '0; DataIn0 = '0; DataIn1 = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic fill_table(input int s);
    for (int p = 0; p < 32; p++) begin
      blk_d[s][2*p]   = vtab[p % 8].d0;
      blk_d[s][2*p+1] = vtab[p % 8].d1;
      blk_e[s][2*p]   = vtab[p % 8].e0;
      blk_e[s][2*p+1] = vtab[p % 8].e1;
    end
  endtask

  task automatic fill_const(input int s, input int v);
    for (int i = 0; i < 64; i++) begin
      blk_d[s][i] = 9'(v);
      blk_e[s][i] = 8'(v + 128);
    end
  endtask

  task automatic fill_ramp(input int s, input int off);
    for (int i = 0; i < 64; i++) begin
      blk_d[s][i] = 9'(i*2 - 64 + off);
      blk_e[s][i] = 8'(i*2 + 64 + off);
    end
  endtask

  // mode 0: raster order; mode 1: reverse order with the (7,3) pair deferred to the end.
  task automatic write_pairs(input int s, input int mode, input int from, input int to);
    int q;
    for (int k = from; k < to; k++) begin
      if (mode == 0)   q = k;
      else if (k < 31) q = 30 - k;
      else             q = 31;
      DataInEnable = 1'b1;
      DataInPage   = 3'(q / 4);
      DataInCount  = 2'(q % 4);
      DataIn0      = blk_d[s][2*q];
      DataIn1      = blk_d[s][2*q+1];
      tick();
    end
    DataInEnable = 1'b0;
  endtask

  task automatic read_block(input int s, input bit toggle, input bit nogap);
    int cnt = 0;
    int cyc = 0;
    while (cnt < 64 && cyc < 2000) begin
      OutReady = toggle ? (cyc % 2 == 0) : 1'b1;
      if (nogap) check("nogap_valid", OutValid, 1);
      if (OutValid) begin
        check("out_index", OutIndex, cnt);
        check("out_data", OutData, blk_e[s][cnt]);
        if (OutReady) begin
          check("out_last", OutLast, cnt == 63);
          cnt++;
        end
      end
      tick();
      cyc++;
    end
    OutReady = 1'b0;
    check("read_done", cnt, 64);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vtab[0] = '{9'sd0,    9'sd0,    8'd128, 8'd128};
`ifdef AQ_DJPEG_OUTBUF_CLAMP_EN
    vtab[1] = '{-9'sd200, 9'sd200,  8'd0,   8'd255};
    vtab[3] = '{9'sd255,  -9'sd256, 8'd255, 8'd0};
    vtab[6] = '{-9'sd129, 9'sd128,  8'd0,   8'd255};
`else
    vtab[1] = '{-9'sd200, 9'sd200,  8'd184, 8'd72};
    vtab[3] = '{9'sd255,  -9'sd256, 8'd127, 8'd128};
    vtab[6] = '{-9'sd129, 9'sd128,  8'd255, 8'd0};
`endif
    vtab[2] = '{-9'sd128, 9'sd127,  8'd0,   8'd255};
    vtab[4] = '{-9'sd1,   9'sd1,    8'd127, 8'd129};
    vtab[5] = '{9'sd100,  -9'sd100, 8'd228, 8'd28};
    vtab[7] = '{9'sd50,   -9'sd50,  8'd178, 8'd78};

    // Reset state
    do_reset();
    check("rst_valid", OutValid, 0);
    check("rst_last", OutLast, 0);
    check("rst_overflow", Overflow, 0);
    check("rst_idle", DataInIdle, 1);
    check("rst_index", OutIndex, 0);
    check("rst_data", OutData, 0);

    // Conversion table through one block
    fill_table(0);
    write_pairs(0, 0, 0, 32);
    read_block(0, 0, 0);

    // All-zero block followed by a second block, streamed gaplessly
    fill_const(0, 0);
    fill_table(1);
    write_pairs(0, 0, 0, 32);
    write_pairs(1, 0, 0, 32);
    read_block(0, 0, 0);
    read_block(1, 0, 1);

    // Three blocks with consumer stalled: third is dropped
    do_reset();
    fill_ramp(0, 0);
    fill_table(1);
    write_pairs(0, 0, 0, 32);
    check("idle_after_blk1", DataInIdle, 1);
    write_pairs(1, 0, 0, 32);
    check("idle_after_blk2", DataInIdle, 0);
    check("ovf_before_blk3", Overflow, 0);
    write_pairs(1, 0, 0, 32);
    check("ovf_after_blk3", Overflow, 1);
    read_block(0, 0, 0);
    read_block(1, 0, 1);
    check("ovf_sticky", Overflow, 1);

    // ProcessInit mid-read at index 20
    fill_ramp(0, 20);
    write_pairs(0, 0, 0, 32);
    OutReady = 1'b1;
    for (int c = 0; c < 200 && !(OutValid && OutIndex == 6'd20); c++) tick();
    check("reach_idx20", OutIndex, 20);
    OutReady = 1'b0;
    ProcessInit = 1'b1;
    tick();
    ProcessInit = 1'b0;
    check("pi_valid", OutValid, 0);
    check("pi_idle", DataInIdle, 1);
    check("pi_overflow", Overflow, 0);
    check("pi_index", OutIndex, 0);
    fill_ramp(1, 40);
    write_pairs(1, 0, 0, 32);
    read_block(1, 0, 0);

    // Consumer toggling ready every cycle
    fill_table(0);
    write_pairs(0, 0, 0, 32);
    read_block(0, 1, 0);

    // Reverse write order; completion only on the (7,3) write
    fill_ramp(1, 10);
    write_pairs(1, 1, 0, 31);
    check("rev_valid_pre", OutValid, 0);
    check("rev_idle_pre", DataInIdle, 1);
    write_pairs(1, 1, 31, 32);
    check("rev_valid_edge", OutValid, 0);
    tick();
    check("rev_valid_lat1", OutValid, 1);
    check("rev_index0", OutIndex, 0);
    read_block(1, 0, 0);

    // Reset mid-block abandons the partial write
    fill_ramp(0, 30);
    write_pairs(0, 0, 0, 16);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_idle", DataInIdle, 1);
    check("midrst_valid", OutValid, 0);
    fill_table(1);
    write_pairs(1, 0, 0, 32);
    read_block(1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
